imem_dmem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (LS).
- Keeps at most one memory transaction outstanding and routes each response back to the requester that issued it.
- Gives LS fixed priority, with a starvation guard that forces an IF grant after a bounded run of LS grants.
- Sits between the fetch/memory stages and the memory macro; drives the core's stall generation through its grant outputs.

---
 rtl/imem_dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (LS). One transaction in flight, LS has fixed priority,
// and a streak counter forces an IF grant after MAX_LS_STREAK LS grants in a
// row while IF is waiting. Grants and the memory request are combinational in
// the issue cycle; responses are steered back combinationally from mem_rvalid.
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // instruction fetch side
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [31:0]           if_rdata_o,
    // load/store side
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [31:0]           ls_wdata_i,
    input  logic [3:0]            ls_be_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [31:0]           ls_rdata_o,
    // memory side
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    typedef enum logic { IDLE, BUSY } state_e;
    typedef enum logic { OWN_IF, OWN_LS } owner_e;

    state_e                state_q,    state_d;
    owner_e                owner_q,    owner_d;
    logic                  owner_we_q, owner_we_d;   // outstanding LS op is a write
    logic                  drop_q,     drop_d;       // outstanding IF response is flushed
    logic [STREAK_W-1:0]   streak_q,   streak_d;

    logic                  resp;
    logic                  issue_ok;
    logic                  ls_win;
    logic                  if_win;
    logic                  if_deliver;

    // Byte-offset bits are ignored; memory sees word-aligned addresses only.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], ls_addr_i[1:0]};

    // Issue, arbitration, memory drive, response steering and next-state logic.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the branches below can leave a latch behind.
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        state_d     = state_q;
        owner_d     = owner_q;
        owner_we_d  = owner_we_q;
        drop_d      = drop_q;
        streak_d    = streak_q;

        // A response only counts while a transaction is outstanding; a stray
        // mem_rvalid in IDLE is dropped on the floor.
        resp       = !rst_i && (state_q == BUSY) && mem_rvalid_i;
        issue_ok   = !rst_i && ((state_q == IDLE) || resp);
        ls_win     = issue_ok && ls_req_i && !(if_req_i && (streak_q == STREAK_MAX));
        if_win     = issue_ok && !ls_win && if_req_i;
        if_deliver = resp && (owner_q == OWN_IF) && !drop_q && !if_flush_i;

        // Response routing back to the owner of the outstanding transaction.
        if (resp) begin
            state_d = IDLE;
            drop_d  = 1'b0;
            if (owner_q == OWN_IF) begin
                if_rvalid_o = if_deliver;
                if_rdata_o  = if_deliver ? mem_rdata_i : '0;
            end else begin
                ls_rvalid_o = 1'b1;
                ls_rdata_o  = owner_we_q ? '0 : mem_rdata_i;
            end
        end else if ((state_q == BUSY) && (owner_q == OWN_IF) && if_flush_i) begin
            drop_d = 1'b1;
        end

        // New issue (from IDLE or back-to-back with the response above).
        if (ls_win) begin
            ls_gnt_o    = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = {ls_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_o = ls_wdata_i;
            mem_be_o    = ls_be_i;
            state_d     = BUSY;
            owner_d     = OWN_LS;
            owner_we_d  = ls_we_i;
            if (!if_req_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (if_win) begin
            if_gnt_o    = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_be_o    = 4'hF;
            state_d     = BUSY;
            owner_d     = OWN_IF;
            owner_we_d  = 1'b0;
            streak_d    = '0;
        end
    end

    // State, ownership, flush and streak registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            owner_we_q <= 1'b0;
            drop_q     <= 1'b0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            drop_q     <= drop_d;
            streak_q   <= streak_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level reference model.
module tb_imem_dmem_arbiter;

    localparam int ADDR_WIDTH    = 32;
    localparam int MAX_LS_STREAK = 4;
    localparam int RAND_CYCLES   = 3000;

    logic                  clk;
    logic                  rst;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [31:0]           ls_wdata;
    logic [3:0]            ls_be;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [31:0]           ls_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    imem_dmem_arbiter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MAX_LS_STREAK(MAX_LS_STREAK)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .ls_req_i    (ls_req),
        .ls_we_i     (ls_we),
        .ls_addr_i   (ls_addr),
        .ls_wdata_i  (ls_wdata),
        .ls_be_i     (ls_be),
        .ls_gnt_o    (ls_gnt),
        .ls_rvalid_o (ls_rvalid),
        .ls_rdata_o  (ls_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the directed sequence.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // mid-cycle, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        if_flush   = 1'b0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        ls_be      = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".gnt"},    {62'd0, if_gnt, ls_gnt}, 64'd0);
        check({tag, ".rvalid"}, {62'd0, if_rvalid, ls_rvalid}, 64'd0);
        check({tag, ".rdata"},  {if_rdata, ls_rdata}, 64'd0);
        check({tag, ".memctl"}, {58'd0, mem_req, mem_we, mem_be}, 64'd0);
        check({tag, ".memaddr"}, 64'(mem_addr), 64'd0);
        check({tag, ".memwdata"}, 64'(mem_wdata), 64'd0);
    endtask

    // Reference model: one record per outstanding transaction.
    typedef struct {
        bit is_if;
        bit we;
        bit dropped;
    } txn_t;

    txn_t txn_q[$];

    initial begin
        int   streak;
        int   lat_left;
        bit   resp, can_issue, l_win, i_win, l_won, i_won;
        bit   e_if_rv, e_ls_rv;
        logic [31:0] e_if_rd, e_ls_rd;
        logic [ADDR_WIDTH-1:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        bit   e_we;
        string seq_tag;

        idle_inputs();
        rst = 1'b1;

        // ---------------- reset state ----------------
        tick();
        settle();
        check_quiet("reset_held");
        tick();
        rst = 1'b0;
        settle();
        check_quiet("reset_released");

        // ---------------- IF only, latency 1 ----------------
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        settle();
        check("if1.if_gnt",   if_gnt, 1);
        check("if1.ls_gnt",   ls_gnt, 0);
        check("if1.mem_req",  mem_req, 1);
        check("if1.mem_addr", mem_addr, 32'h104);
        check("if1.mem_be",   mem_be, 4'hF);
        check("if1.mem_we",   mem_we, 0);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        settle();
        check("if1.if_rvalid", if_rvalid, 1);
        check("if1.if_rdata",  if_rdata, 32'h1234_5678);
        check("if1.ls_rvalid", ls_rvalid, 0);
        tick();
        idle_inputs();
        settle();
        check("if1.after_rvalid", if_rvalid, 0);

        // ---------------- collision, streak 0 ----------------
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        settle();
        check("col.ls_gnt",   ls_gnt, 1);
        check("col.if_gnt",   if_gnt, 0);
        check("col.mem_addr", mem_addr, 32'h200);
        tick();
        ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        settle();
        check("col.ls_rvalid", ls_rvalid, 1);
        check("col.ls_rdata",  ls_rdata, 32'hCAFE_0001);
        check("col.if_rvalid", if_rvalid, 0);
        check("col.if_gnt_b2b", if_gnt, 1);
        check("col.mem_addr_if", mem_addr, 32'h400);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        settle();
        check("col.if_rvalid2", if_rvalid, 1);
        check("col.if_rdata2",  if_rdata, 32'h1111_2222);
        check("col.ls_rvalid2", ls_rvalid, 0);
        tick();
        idle_inputs();

        // ---------------- starvation guard ----------------
        // Expected grant order with both requesting: L L L L I L.
        if_req = 1'b1; if_addr = 32'h500;
        ls_req = 1'b1; ls_addr = 32'h600;
        settle();
        check("starv0.ls_gnt", ls_gnt, 1);
        check("starv0.if_gnt", if_gnt, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            mem_rvalid = 1'b1; mem_rdata = 32'(k);
            settle();
            seq_tag = $sformatf("starv%0d", k);
            check({seq_tag, ".ls_gnt"}, ls_gnt, (k == 4) ? 1'b0 : 1'b1);
            check({seq_tag, ".if_gnt"}, if_gnt, (k == 4) ? 1'b1 : 1'b0);
        end
        tick();
        if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        settle();
        check("starv.last_ls_rvalid", ls_rvalid, 1);
        tick();
        idle_inputs();

        // ---------------- LS write ----------------
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h303; ls_be = 4'b0011;
        ls_wdata = 32'hDEAD_BEEF;
        settle();
        check("wr.ls_gnt",    ls_gnt, 1);
        check("wr.mem_we",    mem_we, 1);
        check("wr.mem_be",    mem_be, 4'b0011);
        check("wr.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr.mem_addr",  mem_addr, 32'h300);
        tick();
        ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        settle();
        check("wr.ls_rvalid", ls_rvalid, 1);
        check("wr.ls_rdata",  ls_rdata, 0);
        check("wr.if_rvalid", if_rvalid, 0);
        tick();
        idle_inputs();

        // ---------------- flush, latency 3 ----------------
        if_req = 1'b1; if_addr = 32'h700;
        settle();
        check("fl.if_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        settle();
        check("fl.c1_rvalid", if_rvalid, 0);
        tick();
        if_flush = 1'b1;
        settle();
        check("fl.c2_rvalid", if_rvalid, 0);
        check("fl.c2_gnt",    if_gnt, 0);
        tick();
        if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        settle();
        check("fl.dropped_rvalid", if_rvalid, 0);
        check("fl.dropped_rdata",  if_rdata, 0);
        check("fl.dropped_ls",     ls_rvalid, 0);
        tick();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h704;
        settle();
        check("fl.next_gnt",  if_gnt, 1);
        check("fl.next_addr", mem_addr, 32'h704);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        settle();
        check("fl.next_rvalid", if_rvalid, 1);
        check("fl.next_rdata",  if_rdata, 32'h99);
        tick();
        idle_inputs();

        // Flush coinciding with the response, plus a back-to-back IF grant.
        if_req = 1'b1; if_addr = 32'h800;
        settle();
        check("flb.gnt0", if_gnt, 1);
        tick();
        if_addr = 32'h804; if_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        settle();
        check("flb.suppressed", if_rvalid, 0);
        check("flb.gnt1",       if_gnt, 1);
        tick();
        if_req = 1'b0; if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66;
        settle();
        check("flb.new_rvalid", if_rvalid, 1);
        check("flb.new_rdata",  if_rdata, 32'h66);
        tick();
        idle_inputs();

        // ---------------- reset while BUSY, stray response ----------------
        if_req = 1'b1; if_addr = 32'h900;
        settle();
        check("rb.gnt", if_gnt, 1);
        tick();
        if_req = 1'b0; rst = 1'b1;
        settle();
        check_quiet("rb.in_reset");
        tick();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        settle();
        check_quiet("rb.stray");
        tick();
        mem_rvalid = 1'b0; ls_req = 1'b1; ls_addr = 32'hA00;
        settle();
        check("rb.next_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD;
        settle();
        check("rb.next_rvalid", ls_rvalid, 1);
        check("rb.next_rdata",  ls_rdata, 32'hABCD);

        // ---------------- randomized run vs reference model ----------------
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        txn_q.delete();
        streak   = 0;
        lat_left = 0;
        i_won    = 1'b0;
        l_won    = 1'b0;

        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            if (i_won || !if_req) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (l_won || !ls_req) begin
                ls_req   = ($urandom_range(0, 2) != 0);
                ls_we    = $urandom_range(0, 1) == 1;
                ls_addr  = $urandom;
                ls_wdata = $urandom;
                ls_be    = 4'($urandom);
            end
            if_flush   = ($urandom_range(0, 7) == 0);
            mem_rdata  = $urandom;
            mem_rvalid = (txn_q.size() > 0) ? (lat_left == 1) : ($urandom_range(0, 9) == 0);

            resp      = (txn_q.size() > 0) && mem_rvalid;
            can_issue = (txn_q.size() == 0) || resp;
            l_win     = can_issue && ls_req && !(if_req && streak >= MAX_LS_STREAK);
            i_win     = can_issue && !l_win && if_req;

            e_if_rv = resp && txn_q[0].is_if && !txn_q[0].dropped && !if_flush;
            e_ls_rv = resp && !txn_q[0].is_if;
            e_if_rd = e_if_rv ? mem_rdata : 32'd0;
            e_ls_rd = (e_ls_rv && !txn_q[0].we) ? mem_rdata : 32'd0;

            e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
            if (l_win) begin
                e_we = ls_we; e_addr = ls_addr & ~32'h3; e_wdata = ls_wdata; e_be = ls_be;
            end else if (i_win) begin
                e_addr = if_addr & ~32'h3; e_be = 4'hF;
            end

            settle();
            check("rnd.if_gnt",    if_gnt, i_win);
            check("rnd.ls_gnt",    ls_gnt, l_win);
            check("rnd.mem_req",   mem_req, l_win || i_win);
            check("rnd.mem_we",    mem_we, e_we);
            check("rnd.mem_addr",  mem_addr, e_addr);
            check("rnd.mem_wdata", mem_wdata, e_wdata);
            check("rnd.mem_be",    mem_be, e_be);
            check("rnd.if_rvalid", if_rvalid, e_if_rv);
            check("rnd.if_rdata",  if_rdata, e_if_rd);
            check("rnd.ls_rvalid", ls_rvalid, e_ls_rv);
            check("rnd.ls_rdata",  ls_rdata, e_ls_rd);

            if (resp) begin
                void'(txn_q.pop_front());
            end else if (txn_q.size() > 0 && txn_q[0].is_if && if_flush) begin
                txn_q[0].dropped = 1'b1;
            end
            if (l_win || i_win) begin
                txn_q.push_back('{is_if: i_win, we: (l_win && ls_we), dropped: 1'b0});
                lat_left = $urandom_range(1, 3);
            end else if (txn_q.size() > 0) begin
                lat_left--;
            end
            if (l_win) begin
                streak = if_req ? ((streak < MAX_LS_STREAK) ? streak + 1 : MAX_LS_STREAK) : 0;
            end else if (i_win) begin
                streak = 0;
            end
            i_won = i_win;
            l_won = l_win;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
